seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1101, reset-time pattern (PAT_W bits, MSB is first bit received).
REQ-003 SHALL have parameter OVERLAP, default 0; 0 = non-overlapping detection, 1 = overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, match counter width, legal 1..32.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 x  input  1  serial data bit.
REQ-008 in_valid  input  1  x is sampled only when high.
REQ-009 pat_load  input  1  load pat_in as active pattern.
REQ-010 pat_in  input  PAT_W  new pattern value.
REQ-011 cnt_clr  input  1  synchronous clear of match_count.
REQ-012 y  output  1  registered one-cycle match pulse.
REQ-013 match_count  output  CNT_W  saturating number of matches.

Function
REQ-014 SHALL keep a PAT_W-bit history shift register (new bit into LSB), a fill counter 0..PAT_W, and an active-pattern register.
REQ-015 On a clk edge with in_valid=1 and pat_load=0, SHALL shift x into history and increment fill (saturating at PAT_W).
REQ-016 A match SHALL be declared on that edge when the updated fill equals PAT_W and the updated history equals the active pattern.
REQ-017 y SHALL be 1 for exactly the one cycle following the edge that accepted the completing bit, and 0 otherwise (Moore, registered).
REQ-018 With in_valid=0, history, fill and pattern SHALL hold, and y SHALL be 0 on the next cycle.
REQ-019 OVERLAP=0: on a match, fill SHALL be cleared to 0; the next valid bit starts a fresh PAT_W-bit window (no bit is discarded).
REQ-020 OVERLAP=1: on a match, fill SHALL remain PAT_W, so any suffix of the matched bits can begin the next match.
REQ-021 pat_load=1 SHALL load pat_in, clear fill to 0, force y to 0 next cycle, and discard any simultaneous in_valid bit.
REQ-022 On each match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1 without wrap.
REQ-023 cnt_clr=1 SHALL set match_count to 0; a simultaneous match SHALL be dropped from the count, but y SHALL still pulse.
REQ-024 pat_load and cnt_clr asserted together SHALL both take effect.

Reset
REQ-025 rst=0 SHALL immediately, without a clock, force y=0, match_count=0, fill=0, history=0, and active pattern=PATTERN.
REQ-026 Reset SHALL abort a partially received pattern; after release, a full PAT_W new valid bits are required for a match.
REQ-027 The first edge that can sample input SHALL be the first rising clk edge with rst=1.

Configuration
REQ-028 Macro SEQDET_COUNT_EN SHALL, when defined, compile in the match counter and cnt_clr behaviour per REQ-022..REQ-024.
REQ-029 Without SEQDET_COUNT_EN, match_count SHALL be constant 0, cnt_clr ignored, no counter flops; y behaviour unchanged.

Verification
REQ-030 Defaults, in_valid=1, x stream 1,1,0,1,1,0,1 -> OVERLAP=0: one y pulse (after bit 4), match_count=1; OVERLAP=1: pulses after bits 4 and 7, match_count=2.
REQ-031 Stream 1,1 then in_valid=0 for 3 cycles then 0,1 -> single y pulse one cycle after the final 1; y=0 throughout the gap.
REQ-032 After bits 1,1, pat_load with pat_in=4'b0110 -> fill=0; following 1,1,0,1 gives no pulse; following 0,1,1,0 gives one pulse.
REQ-033 CNT_W=2, SEQDET_COUNT_EN defined, 5 non-overlapping 1101 matches -> match_count=3 (saturated); cnt_clr pulse -> 0; cnt_clr on a matching edge -> y=1, count stays 0.
REQ-034 After bits 1,1,0, drive rst=0 between clock edges -> y=0, match_count=0 immediately; release, send 1 -> no pulse; send 1,1,0,1 -> one pulse.
REQ-035 SEQDET_COUNT_EN undefined, repeat REQ-030 -> identical y pulses, match_count=0 throughout.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-loadable pattern.
//
// Bits arrive MSB-of-pattern first on x. A PAT_W-bit history register collects
// them, and a fill counter tracks how many bits of the current window are valid.
// y is a registered, one-cycle match pulse.
//
// Optional feature: define SEQDET_COUNT_EN to build in the saturating match
// counter (match_count) and its synchronous clear (cnt_clr). In the default
// build, match_count is tied to 0 and cnt_clr is ignored.
//
// Input qualification: there is no back-pressure. x is consumed on every rising
// edge where in_valid=1 and pat_load=0. When pat_load=1, pat_in is consumed and
// a concurrent in_valid bit is discarded. When in_valid=0, all window state holds.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               OVERLAP = 0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] fill_inc;
  logic              y_q;
  logic              match;

  // Next window state and the match decision for the current edge.
  always_comb begin
    hist_d   = hist_q;
    pat_d    = pat_q;
    fill_d   = fill_q;
    fill_inc = fill_q;
    match    = 1'b0;
    if (pat_load) begin
      // A new pattern restarts the window. A concurrent data bit is dropped.
      pat_d  = pat_in;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d   = {hist_q[PAT_W-2:0], x};
      fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_ONE);
      match    = (fill_inc == FILL_FULL) && (hist_d == pat_q);
      // Non-overlapping mode starts a fresh window after a hit. Overlapping
      // mode keeps the window full, so a suffix can seed the next hit.
      if (match && (OVERLAP == 0)) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
    end
  end

  // Window registers and the registered match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      pat_q  <= PATTERN;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      y_q    <= match;
    end
  end

  assign y = y_q;

`ifdef SEQDET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter. A clear wins over a concurrent match.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: three detectors driven from one input stream
// (non-overlapping, overlapping, and non-overlapping with a 2-bit counter).
// Each is compared against a reference model that replays the accepted bit stream.
module tb_seq_detector_param;

  localparam int        PW  = 4;
`ifdef SEQDET_COUNT_EN
  localparam bit        CEN = 1'b1;
`else
  localparam bit        CEN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          x, in_valid, pat_load, cnt_clr;
  logic [PW-1:0] pat_in;
  logic          y0, y1, y2;
  logic [7:0]    mc0, mc1;
  logic [1:0]    mc2;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y0), .match_count(mc0));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y1), .match_count(mc1));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y2), .match_count(mc2));

  // ---------------- scoreboard / reference model ----------------
  int   checks = 0;
  int   errors = 0;
  bit   acc[$];          // every bit accepted since time zero
  int   win_start[3];    // index in acc where each detector's window begins
  bit   ovl[3]     = '{1'b0, 1'b1, 1'b0};
  int   cmax[3]    = '{255, 255, 3};
  bit   exp_y[3];
  int   exp_cnt[3];
  logic [PW-1:0] mpat;
  int   pulses[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      win_start[k] = acc.size();
      exp_y[k]     = 1'b0;
      exp_cnt[k]   = 0;
    end
    mpat = 4'b1101;
  endtask

  // Model one rising edge using the values the DUT sampled.
  task automatic model_edge(input bit xv, input bit v, input bit ld,
                            input logic [PW-1:0] pin, input bit clr);
    bit m[3];
    int tail;
    for (int k = 0; k < 3; k++) m[k] = 1'b0;
    if (ld) begin
      mpat = pin;
      for (int k = 0; k < 3; k++) win_start[k] = acc.size();
    end else if (v) begin
      acc.push_back(xv);
      tail = 0;
      if (acc.size() >= PW)
        for (int i = 0; i < PW; i++) tail = tail * 2 + int'(acc[acc.size() - PW + i]);
      for (int k = 0; k < 3; k++) begin
        if ((acc.size() - win_start[k] >= PW) && (tail == int'(mpat))) begin
          m[k] = 1'b1;
          if (!ovl[k]) win_start[k] = acc.size();
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      exp_y[k] = m[k];
      if (!CEN || clr)                   exp_cnt[k] = 0;
      else if (m[k] && exp_cnt[k] < cmax[k]) exp_cnt[k] = exp_cnt[k] + 1;
    end
  endtask

  task automatic compare_all();
    check("y0", 32'(y0), 32'(exp_y[0]));
    check("y1", 32'(y1), 32'(exp_y[1]));
    check("y2", 32'(y2), 32'(exp_y[2]));
    check("cnt0", 32'(mc0), 32'(exp_cnt[0]));
    check("cnt1", 32'(mc1), 32'(exp_cnt[1]));
    check("cnt2", 32'(mc2), 32'(exp_cnt[2]));
    pulses[0] += int'(y0);
    pulses[1] += int'(y1);
    pulses[2] += int'(y2);
  endtask

  // ---------------- driver tasks (entered and left at negedge) ----------------
  task automatic step(input bit xv, input bit v, input bit ld,
                      input logic [PW-1:0] pin, input bit clr);
    x = xv; in_valid = v; pat_load = ld; pat_in = pin; cnt_clr = clr;
    @(posedge clk);
    model_edge(xv, v, ld, pin, clr);
    #2;
    compare_all();
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_y0", 32'(y0), 32'd0);
    check("rst_y1", 32'(y1), 32'd0);
    check("rst_cnt0", 32'(mc0), 32'd0);
    check("rst_cnt2", 32'(mc2), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_pulses();
    for (int k = 0; k < 3; k++) pulses[k] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; x = 1'b0; in_valid = 1'b0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    model_reset();
    #2;
    check("por_y0", 32'(y0), 32'd0);
    check("por_cnt1", 32'(mc1), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // Stream 1101101: non-overlapping sees one hit, overlapping sees two.
    clear_pulses();
    send_bits(32'b1101101, 7);
    check("ovl0_pulses", 32'(pulses[0]), 32'd1);
    check("ovl1_pulses", 32'(pulses[1]), 32'd2);
    check("ovl0_count", 32'(mc0), CEN ? 32'd1 : 32'd0);
    check("ovl1_count", 32'(mc1), CEN ? 32'd2 : 32'd0);

    // Gap with in_valid low in the middle of the pattern.
    async_reset();
    clear_pulses();
    send_bits(32'b11, 2);
    idle(3);
    check("gap_pulses", 32'(pulses[0]), 32'd0);
    send_bits(32'b01, 2);
    check("gap_y_final", 32'(y0), 32'd1);
    check("gap_total", 32'(pulses[0]), 32'd1);

    // Runtime pattern load aborts the partial window.
    async_reset();
    clear_pulses();
    send_bits(32'b11, 2);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    send_bits(32'b1101, 4);
    check("load_old_pat", 32'(pulses[0]), 32'd0);
    send_bits(32'b0110, 4);
    check("load_new_pat", 32'(pulses[0]), 32'd1);

    // Saturation of the 2-bit counter, then clears.
    async_reset();
    for (int i = 0; i < 5; i++) send_bits(32'b1101, 4);
    check("sat_cnt2", 32'(mc2), CEN ? 32'd3 : 32'd0);
    check("sat_cnt0", 32'(mc0), CEN ? 32'd5 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    check("clr_cnt2", 32'(mc2), 32'd0);
    send_bits(32'b110, 3);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    check("clr_hit_y", 32'(y2), 32'd1);
    check("clr_hit_cnt", 32'(mc2), 32'd0);
    // Load and clear on the same edge both take effect.
    send_bits(32'b1101, 4);
    step(1'b0, 1'b0, 1'b1, 4'b1101, 1'b1);
    check("ld_clr_cnt", 32'(mc0), 32'd0);

    // Reset in the middle of a pattern.
    async_reset();
    send_bits(32'b110, 3);
    async_reset();
    clear_pulses();
    send_bits(32'b1, 1);
    check("rst_abort", 32'(pulses[0]), 32'd0);
    send_bits(32'b1101, 4);
    check("rst_fresh", 32'(pulses[0]), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 1) != 0) ? 4'b1101 : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 39) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
